// File: rtl/ctrl_pkt_decoder.sv
// Control-stream decoder: turns a header beat plus one payload beat into a single
// match-action configuration write, stalling the stream while the write is pending.
module ctrl_pkt_decoder #(
    parameter int         C_S_AXIS_DATA_WIDTH  = 512,
    parameter int         C_S_AXIS_TUSER_WIDTH = 128,
    parameter int         CMD_DATA_WIDTH       = 256,
    parameter logic [7:0] OP_WRITE             = 8'h01,
    parameter int         CNT_WIDTH            = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic                              cfg_valid,
    input  logic                              cfg_ready,
    output logic [7:0]                        cfg_mod_id,
    output logic [15:0]                       cfg_index,
    output logic [CMD_DATA_WIDTH-1:0]         cfg_data,
    output logic [CNT_WIDTH-1:0]              cmd_cnt,
    output logic [CNT_WIDTH-1:0]              drop_cnt
);
    localparam int CMD_BYTES = CMD_DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_ISSUE = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                      r_state, w_state_next;
    logic                        r_tready, w_tready_next;
    logic                        r_cfg_valid, w_cfg_valid_next;
    logic [7:0]                  r_mod_id, w_mod_id_next;
    logic [15:0]                 r_index, w_index_next;
    logic [CMD_DATA_WIDTH-1:0]   r_data, w_data_next;
    logic                        r_last_seen, w_last_seen_next;
    logic [CNT_WIDTH-1:0]        r_cmd_cnt, w_cmd_cnt_next;
    logic [CNT_WIDTH-1:0]        r_drop_cnt, w_drop_cnt_next;

    logic                        w_beat;
    logic                        w_cfg_hs;
    logic                        w_keep_ok;
    logic [7:0]                  w_opcode;
    logic                        w_unused_bits;

    assign w_beat    = s_axis_tvalid && r_tready;
    assign w_cfg_hs  = r_cfg_valid && cfg_ready;
    assign w_keep_ok = &s_axis_tkeep[CMD_BYTES-1:0];
    assign w_opcode  = s_axis_tdata[351:344];
    assign w_unused_bits = ^{s_axis_tuser, s_axis_tkeep, s_axis_tdata};

    // Ready is held low while reset is asserted, and high straight after it.
    assign s_axis_tready = r_tready && !rst;
    assign cfg_valid     = r_cfg_valid;
    assign cfg_mod_id    = r_mod_id;
    assign cfg_index     = r_index;
    assign cfg_data      = r_data;
    assign cmd_cnt       = r_cmd_cnt;
    assign drop_cnt      = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tready    <= 1'b1;
            r_cfg_valid <= 1'b0;
            r_mod_id    <= '0;
            r_index     <= '0;
            r_data      <= '0;
            r_last_seen <= 1'b0;
            r_cmd_cnt   <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_tready    <= w_tready_next;
            r_cfg_valid <= w_cfg_valid_next;
            r_mod_id    <= w_mod_id_next;
            r_index     <= w_index_next;
            r_data      <= w_data_next;
            r_last_seen <= w_last_seen_next;
            r_cmd_cnt   <= w_cmd_cnt_next;
            r_drop_cnt  <= w_drop_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cfg_valid_next = r_cfg_valid;
        w_mod_id_next    = r_mod_id;
        w_index_next     = r_index;
        w_data_next      = r_data;
        w_last_seen_next = r_last_seen;
        w_cmd_cnt_next   = r_cmd_cnt;
        w_drop_cnt_next  = r_drop_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_beat) begin
                    w_mod_id_next = s_axis_tdata[343:336];
                    w_index_next  = {s_axis_tdata[359:352], s_axis_tdata[367:360]};
                    if (s_axis_tlast) begin
                        w_drop_cnt_next = r_drop_cnt + CNT_ONE;
                    end else if (w_opcode != OP_WRITE) begin
                        w_drop_cnt_next = r_drop_cnt + CNT_ONE;
                        w_state_next    = S_DRAIN;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_beat) begin
                    w_data_next = s_axis_tdata[CMD_DATA_WIDTH-1:0];
                    if (!w_keep_ok) begin
                        w_drop_cnt_next = r_drop_cnt + CNT_ONE;
                        w_state_next    = s_axis_tlast ? S_IDLE : S_DRAIN;
                    end else begin
                        w_last_seen_next = s_axis_tlast;
                        w_cfg_valid_next = 1'b1;
                        w_state_next     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (w_cfg_hs) begin
                    w_cfg_valid_next = 1'b0;
                    w_cmd_cnt_next   = r_cmd_cnt + CNT_ONE;
                    w_state_next     = r_last_seen ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_beat && s_axis_tlast) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // The stream stalls only while a command is waiting for its handshake.
        w_tready_next = (w_state_next != S_ISSUE);
    end
endmodule

// File: tb/tb_ctrl_pkt_decoder.sv
// Bench for ctrl_pkt_decoder: directed packets, a command scoreboard and direct
// checks of back-pressure, hold behaviour and the debug counters.
module tb_ctrl_pkt_decoder;
    logic         clk;
    logic         rst;
    logic [511:0] s_axis_tdata;
    logic [63:0]  s_axis_tkeep;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [7:0]   cfg_mod_id;
    logic [15:0]  cfg_index;
    logic [255:0] cfg_data;
    logic [31:0]  cmd_cnt;
    logic [31:0]  drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]   mod_id;
        logic [15:0]  index;
        logic [255:0] data;
    } exp_t;
    exp_t exp_q[$];

    ctrl_pkt_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_mod_id    (cfg_mod_id),
        .cfg_index     (cfg_index),
        .cfg_data      (cfg_data),
        .cmd_cnt       (cmd_cnt),
        .drop_cnt      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Scoreboard monitor: every command handshake is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && cfg_valid && cfg_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL cmd: got unexpected mod=%0h idx=%0h, required no command",
                         cfg_mod_id, cfg_index);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cfg_mod_id !== e.mod_id || cfg_index !== e.index || cfg_data !== e.data) begin
                    n_bad++;
                    $display("FAIL cmd: got mod=%0h idx=%0h data=%0h required mod=%0h idx=%0h data=%0h",
                             cfg_mod_id, cfg_index, cfg_data, e.mod_id, e.index, e.data);
                end else begin
                    $display("cmd  mod=%0h idx=%0h data=%0h", cfg_mod_id, cfg_index, cfg_data);
                end
            end
        end
    end

    function automatic logic [511:0] make_hdr(input logic [7:0] mod_id, input logic [7:0] op,
                                             input logic [15:0] idx);
        logic [511:0] d;
        d = {64{8'h33}};
        d[343:336] = mod_id;
        d[351:344] = op;
        d[359:352] = idx[15:8];
        d[367:360] = idx[7:0];
        return d;
    endfunction

    function automatic logic [511:0] make_pay(input logic [7:0] lo);
        return {{32{8'h5A}}, {32{lo}}};
    endfunction

    task automatic send_beat(input logic [511:0] data, input logic [63:0] keep, input logic last);
        int n;
        s_axis_tdata  = data;
        s_axis_tkeep  = keep;
        s_axis_tlast  = last;
        s_axis_tuser  = {4{$urandom}};
        s_axis_tvalid = 1'b1;
        n = 0;
        while (!s_axis_tready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_accept: got tready=0 for 100 cycles, required 1");
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] mod_id, input logic [15:0] idx, input logic [7:0] lo);
        exp_t e;
        logic [511:0] p;
        p = make_pay(lo);
        e.mod_id = mod_id;
        e.index  = idx;
        e.data   = p[255:0];
        exp_q.push_back(e);
    endtask

    // Header beat, payload beat, then filler beats; tlast on the final one.
    task automatic send_pkt(input logic [7:0] mod_id, input logic [7:0] op, input logic [15:0] idx,
                            input logic [7:0] lo, input int nbeats, input logic [63:0] keep1);
        send_beat(make_hdr(mod_id, op, idx), '1, nbeats == 1);
        for (int b = 1; b < nbeats; b++) begin
            if (b == 1) send_beat(make_pay(lo), keep1, nbeats == 2);
            else        send_beat({16{32'hDEAD0000 + b}}, '1, b == nbeats - 1);
        end
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cmd_timeout: got %0d pending commands, required 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; cfg_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", s_axis_tready, 0);
        check("rst_cfg_valid", cfg_valid, 0);
        check("rst_mod_id", cfg_mod_id, 0);
        check("rst_index", cfg_index, 0);
        check("rst_data", cfg_data, 0);
        check("rst_cmd_cnt", cmd_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        rst = 1'b0;
        #1;
        check("post_rst_tready", s_axis_tready, 1);

        // Basic command with 1-cycle latency and a one-cycle valid pulse.
        cfg_ready = 1'b1;
        push_exp(8'h05, 16'h002a, 8'hA5);
        send_pkt(8'h05, 8'h01, 16'h002a, 8'hA5, 2, '1);
        check("t1_valid_latency", cfg_valid, 1);
        @(posedge clk); #1;
        check("t1_valid_pulse", cfg_valid, 0);
        check("t1_cmd_cnt", cmd_cnt, 1);
        check("t1_tready", s_axis_tready, 1);

        // Back-pressure: command held while cfg_ready is low.
        cfg_ready = 1'b0;
        push_exp(8'h07, 16'h1234, 8'hC3);
        send_pkt(8'h07, 8'h01, 16'h1234, 8'hC3, 2, '1);
        for (int c = 0; c < 5; c++) begin
            check("t2_hold_valid", cfg_valid, 1);
            check("t2_hold_tready", s_axis_tready, 0);
            check("t2_hold_mod", cfg_mod_id, 8'h07);
            check("t2_hold_idx", cfg_index, 16'h1234);
            @(posedge clk); #1;
        end
        cfg_ready = 1'b1;
        @(posedge clk); #1;
        check("t2_valid_drop", cfg_valid, 0);
        check("t2_tready_back", s_axis_tready, 1);
        check("t2_cmd_cnt", cmd_cnt, 2);

        // Short single-beat packet is dropped.
        send_pkt(8'h09, 8'h01, 16'h0005, 8'h00, 1, '1);
        @(posedge clk); #1;
        check("t3_drop_cnt", drop_cnt, 1);
        check("t3_tready", s_axis_tready, 1);
        check("t3_valid", cfg_valid, 0);

        // Wrong opcode, 4 beats, all drained; next packet still decodes.
        send_pkt(8'h03, 8'h02, 16'h0007, 8'h11, 4, '1);
        @(posedge clk); #1;
        check("t4_drop_cnt", drop_cnt, 2);
        check("t4_cmd_cnt", cmd_cnt, 2);
        push_exp(8'h21, 16'hBEEF, 8'h3C);
        send_pkt(8'h21, 8'h01, 16'hBEEF, 8'h3C, 2, '1);
        wait_drained();
        check("t4_next_cmd_cnt", cmd_cnt, 3);

        // 4-beat valid packet with drained tail, then a back-to-back packet.
        push_exp(8'h42, 16'h0100, 8'h96);
        push_exp(8'h43, 16'h0101, 8'h69);
        send_pkt(8'h42, 8'h01, 16'h0100, 8'h96, 4, '1);
        send_pkt(8'h43, 8'h01, 16'h0101, 8'h69, 2, '1);
        wait_drained();
        check("t5_cmd_cnt", cmd_cnt, 5);
        check("t5_drop_cnt", drop_cnt, 2);

        // Payload with a missing byte enable in the command region is dropped.
        send_pkt(8'h50, 8'h01, 16'h0002, 8'h77, 2, 64'hFFFF_FFFF_FFFF_FFFE);
        @(posedge clk); #1;
        check("t6_keep_drop", drop_cnt, 3);
        check("t6_keep_cmd_cnt", cmd_cnt, 5);
        check("t6_keep_valid", cfg_valid, 0);

        // Reset while waiting for the payload beat, then a fresh packet.
        send_beat(make_hdr(8'h60, 8'h01, 16'h0060), '1, 1'b0);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check("t7_rst_valid", cfg_valid, 0);
            check("t7_rst_tready", s_axis_tready, 0);
            check("t7_rst_cmd_cnt", cmd_cnt, 0);
            check("t7_rst_drop_cnt", drop_cnt, 0);
        end
        rst = 1'b0;
        #1;
        check("t7_tready", s_axis_tready, 1);
        push_exp(8'h61, 16'hA0B1, 8'hE7);
        send_pkt(8'h61, 8'h01, 16'hA0B1, 8'hE7, 2, '1);
        wait_drained();
        check("t7_cmd_cnt", cmd_cnt, 1);
        check("t7_drop_cnt", drop_cnt, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ctrl_pkt_decoder.md
Name: ctrl_pkt_decoder

Overview:
Consumes the control-path AXI Stream that the packet parser diverts for UDP destination port 0xf1f2. Decodes a fixed control header and one payload beat into a single configuration-write command for the match-action tables. Applies back-pressure while a command is outstanding. Keeps good-command and drop counters for debug.

Parameters:
C_S_AXIS_DATA_WIDTH, 512, control-stream data width; must be 512.
C_S_AXIS_TUSER_WIDTH, 128, tuser width; tuser is ignored.
CMD_DATA_WIDTH, 256, width of the write payload; must be a multiple of 8 and no more than 512.
OP_WRITE, 8'h01, opcode value that is accepted.
CNT_WIDTH, 32, width of the statistics counters.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_axis_tdata  in  512  control packet data; byte k is tdata[8k+7:8k]
s_axis_tkeep  in  64  byte enables
s_axis_tuser  in  128  unused
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  beat accepted when tvalid&&tready
s_axis_tlast  in  1  last beat of packet
cfg_valid  out  1  command valid
cfg_ready  in  1  command accepted when cfg_valid&&cfg_ready
cfg_mod_id  out  8  target module id
cfg_index  out  16  table entry index
cfg_data  out  CMD_DATA_WIDTH  entry payload
cmd_cnt  out  CNT_WIDTH  commands issued
drop_cnt  out  CNT_WIDTH  packets dropped

Behaviour:
Packet format:
- Beat 0: Eth+IPv4+UDP in bytes 0..41.
- Byte 42 = mod_id; byte 43 = opcode.
- Bytes 44..45 = index, network order (byte 44 is the MSB).
- Beat 1: payload = tdata[CMD_DATA_WIDTH-1:0].
- Further beats are discarded.

Reset (rst high at a clock edge):
- State goes to IDLE.
- s_axis_tready=0 during reset; it is 1 from the first non-reset cycle in IDLE.
- cfg_valid=0; cfg_mod_id, cfg_index, cfg_data = 0.
- cmd_cnt = drop_cnt = 0.
- Reset mid-packet abandons the packet with no count. The remainder of that packet is then treated as a new packet, and garbage is decoded.

State machine (all outputs registered):
- IDLE: tready=1. On an accepted beat, latch mod_id, opcode and index.
  - If tlast=1: drop (short packet); drop_cnt++; stay in IDLE.
  - Else if opcode!=OP_WRITE: drop_cnt++; go to DRAIN.
  - Else: go to DATA.
- DATA: tready=1. On an accepted beat, latch the payload.
  - If tkeep[CMD_DATA_WIDTH/8-1:0] is not all ones: drop_cnt++; go to IDLE if tlast, else DRAIN.
  - Else: set last_seen=tlast and go to ISSUE. cfg_valid=1 in the next cycle, so latency from the payload beat to cfg_valid is 1 cycle.
- ISSUE: tready=0; cfg_valid=1; cfg_* are stable until the handshake.
  - On cfg_ready: cfg_valid drops the next cycle; cmd_cnt++; go to IDLE if last_seen, else DRAIN.
  - cfg_ready may be high before cfg_valid; the handshake then completes in the first ISSUE cycle.
- DRAIN: tready=1; accept and discard beats. On tvalid&&tlast, go to IDLE.

Other rules:
- tvalid low in any state causes no change.
- Counters wrap modulo 2^CNT_WIDTH.
- drop_cnt and cmd_cnt never increment in the same cycle.
- Back-to-back packets: an IDLE beat may be accepted in the cycle immediately after the ISSUE handshake.
- Peak throughput is one command per 3 cycles.
- tuser is ignored.

Test Plan:
- Two-beat packet, byte42=0x05, byte43=0x01, bytes44/45=0x00/0x2a, beat1 low 256 bits=0xA5 pattern, tlast on beat1, cfg_ready=1 → one cycle after beat1: cfg_valid=1 for exactly 1 cycle, cfg_mod_id=0x05, cfg_index=0x002a, cfg_data=pattern; cmd_cnt=1.
- Same packet with cfg_ready=0 for 5 cycles → cfg_valid and cfg_* held constant; s_axis_tready=0 throughout; on cfg_ready=1, handshake completes and tready returns to 1 next cycle.
- Single-beat packet (tlast on beat0) → no cfg_valid; drop_cnt=1; tready stays 1.
- Opcode 0x02 in a 4-beat packet → all 4 beats accepted, no cfg_valid, drop_cnt=1; the next valid packet then decodes correctly.
- 4-beat valid packet → command issued after beat1; beats 2..3 drained; a following packet decodes normally, with cmd_cnt=2 after both packets.
- Assert rst in the DATA state, then send a fresh valid packet → cfg_valid stays 0 during reset, counters read 0, and the new packet produces a correct command.
